// File: rtl/mcdf_arb_pkg.sv
// Shared types and helpers for the MCDF arbiter.
// Channel ids, FSM states and packet-length decode.
package mcdf_arb_pkg;

  localparam int NCH = 3;
  localparam int CW  = 6;

  typedef logic [1:0] ch_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // 0 -> 4, 1 -> 8, 2 -> 16, 3 -> 32 words
  function automatic logic [CW-1:0] len_words(
    input logic [1:0] code
  );
    logic [CW-1:0] w;
    w = 6'd4;
    return w << code;
  endfunction

endpackage

// File: rtl/mcdf_arb_sel.sv
// Eligibility check and priority/round-robin picker.
// Lowest prio value wins; ties go to the channel after last_id.
module mcdf_arb_sel
  import mcdf_arb_pkg::*;
(
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0][CW-1:0] cnt,
  input  logic [NCH-1:0][1:0]    prio,
  input  logic [NCH-1:0][1:0]    len,
  input  logic [1:0]             last_id,
  output logic                   grant_valid,
  output logic [1:0]             grant_id
);

  logic [NCH-1:0]      elig;
  logic [NCH-1:0][3:0] key;
  logic [3:0]          best;

  // distance of channel c from the round-robin start point
  function automatic logic [1:0] rr_dist(
    input logic [1:0] c,
    input logic [1:0] last
  );
    logic [2:0] v;
    v = {1'b0, c} + 3'd2 - {1'b0, last};
    if (v >= 3'd3) v = v - 3'd3;
    return v[1:0];
  endfunction

  // a channel is eligible once a full packet is buffered
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      elig[c] = req[c] &&
                (cnt[c] >= len_words(len[c]));
    end
  end

  // sort key {prio, rr distance}; all-ones marks ineligible
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      key[c] = 4'hF;
      if (elig[c]) begin
        key[c] = {prio[c], rr_dist(2'(c), last_id)};
      end
    end
  end

  // smallest key wins; keys of eligible channels are unique
  always_comb begin
    grant_valid = |elig;
    grant_id    = 2'd0;
    best        = key[0];
    if (key[1] < best) begin
      best     = key[1];
      grant_id = 2'd1;
    end
    if (key[2] < best) begin
      best     = key[2];
      grant_id = 2'd2;
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF packet arbiter: grants one slave FIFO at a time
// and drains one whole packet into the formatter.
module mcdf_arbiter
  import mcdf_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          slv0_req_i,
  input  logic          slv1_req_i,
  input  logic          slv2_req_i,
  input  logic          slv0_val_i,
  input  logic          slv1_val_i,
  input  logic          slv2_val_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic [5:0]    slv0_margin_i,
  input  logic [5:0]    slv1_margin_i,
  input  logic [5:0]    slv2_margin_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [1:0]    slv0_len_i,
  input  logic [1:0]    slv1_len_i,
  input  logic [1:0]    slv2_len_i,
  input  logic          f2a_req_i,
  output logic          a2s0_ack_o,
  output logic          a2s1_ack_o,
  output logic          a2s2_ack_o,
  output logic          a2f_val_o,
  output logic [DW-1:0] a2f_data_o,
  output logic [1:0]    a2f_id_o,
  output logic          a2f_sop_o,
  output logic          a2f_eop_o,
  output logic          a2f_busy_o
);

  logic [NCH-1:0]         req;
  logic [NCH-1:0]         val;
  logic [NCH-1:0]         ack;
  logic [NCH-1:0][DW-1:0] data;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0][1:0]    prio;
  logic [NCH-1:0][1:0]    len;

  arb_state_e    state;
  arb_state_e    state_nx;
  ch_id_t        id;
  ch_id_t        last;
  ch_id_t        gnt_id;
  logic          gnt_valid;
  logic          grant;
  logic [CW-1:0] plen;
  logic [CW-1:0] rem;
  logic [CW-1:0] wcnt;
  logic [1:0]    len_sel;
  logic          val_sel;
  logic [DW-1:0] data_sel;

  logic          fwd_val;
  logic [DW-1:0] fwd_data;
  logic          fwd_sop;
  logic          fwd_eop;

  assign req  = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign val  = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign data = {slv2_data_i, slv1_data_i, slv0_data_i};
  assign prio = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign len  = {slv2_len_i, slv1_len_i, slv0_len_i};

  // occupancy from free space; margin 0 means full (32)
  assign cnt[0] = 6'd32 - slv0_margin_i;
  assign cnt[1] = 6'd32 - slv1_margin_i;
  assign cnt[2] = 6'd32 - slv2_margin_i;

  mcdf_arb_sel u_sel (
    .req         (req),
    .cnt         (cnt),
    .prio        (prio),
    .len         (len),
    .last_id     (last),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  assign grant = (state == IDLE) && f2a_req_i && gnt_valid;

  // length code of the channel about to be granted
  always_comb begin
    len_sel = len[0];
    case (gnt_id)
      2'd1:    len_sel = len[1];
      2'd2:    len_sel = len[2];
      default: len_sel = len[0];
    endcase
  end

  // only the granted channel's read data is forwarded
  always_comb begin
    val_sel  = val[0];
    data_sel = data[0];
    case (id)
      2'd1: begin
        val_sel  = val[1];
        data_sel = data[1];
      end
      2'd2: begin
        val_sel  = val[2];
        data_sel = data[2];
      end
      default: begin
        val_sel  = val[0];
        data_sel = data[0];
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = XFER;
      XFER:    if (rem == 6'd1) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // latch packet context at grant; count down acks
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      id   <= 2'd0;
      last <= 2'd2;
      plen <= '0;
      rem  <= '0;
    end else if (grant) begin
      id   <= gnt_id;
      last <= gnt_id;
      plen <= len_words(len_sel);
      rem  <= len_words(len_sel);
    end else if (state == XFER) begin
      rem  <= rem - 6'd1;
    end
  end

  // read strobe to the granted FIFO for the whole XFER phase
  always_comb begin
    ack = '0;
    if (state == XFER) begin
      case (id)
        2'd0:    ack[0] = 1'b1;
        2'd1:    ack[1] = 1'b1;
        2'd2:    ack[2] = 1'b1;
        default: ack    = '0;
      endcase
    end
  end

  // register returned words toward the formatter with sop/eop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fwd_val  <= 1'b0;
      fwd_data <= '0;
      fwd_sop  <= 1'b0;
      fwd_eop  <= 1'b0;
      wcnt     <= '0;
    end else begin
      fwd_val <= 1'b0;
      fwd_sop <= 1'b0;
      fwd_eop <= 1'b0;
      if (grant) begin
        wcnt <= '0;
      end else if ((state != IDLE) && val_sel) begin
        fwd_val  <= 1'b1;
        fwd_data <= data_sel;
        fwd_sop  <= (wcnt == '0);
        fwd_eop  <= (wcnt == plen - 6'd1);
        wcnt     <= wcnt + 6'd1;
      end
    end
  end

  assign a2s0_ack_o = ack[0];
  assign a2s1_ack_o = ack[1];
  assign a2s2_ack_o = ack[2];
  assign a2f_val_o  = fwd_val;
  assign a2f_data_o = fwd_data;
  assign a2f_sop_o  = fwd_sop;
  assign a2f_eop_o  = fwd_eop;
  assign a2f_id_o   = id;
  assign a2f_busy_o = (state != IDLE);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Bench for mcdf_arbiter: FIFO models, cycle-level
// reference model, directed scenarios and random traffic.
module tb_mcdf_arbiter;

  localparam int DW = 32;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [2:0]    req;
  logic [2:0]    val;
  logic [2:0]    ack;
  logic [DW-1:0] data   [3];
  logic [5:0]    margin [3];
  logic [1:0]    prio   [3];
  logic [1:0]    lenc   [3];
  logic          f2a_req;
  logic          a2f_val;
  logic          a2f_sop;
  logic          a2f_eop;
  logic          a2f_busy;
  logic [DW-1:0] a2f_data;
  logic [1:0]    a2f_id;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  mcdf_arbiter #(.DW(DW)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .slv0_req_i    (req[0]),
    .slv1_req_i    (req[1]),
    .slv2_req_i    (req[2]),
    .slv0_val_i    (val[0]),
    .slv1_val_i    (val[1]),
    .slv2_val_i    (val[2]),
    .slv0_data_i   (data[0]),
    .slv1_data_i   (data[1]),
    .slv2_data_i   (data[2]),
    .slv0_margin_i (margin[0]),
    .slv1_margin_i (margin[1]),
    .slv2_margin_i (margin[2]),
    .slv0_prio_i   (prio[0]),
    .slv1_prio_i   (prio[1]),
    .slv2_prio_i   (prio[2]),
    .slv0_len_i    (lenc[0]),
    .slv1_len_i    (lenc[1]),
    .slv2_len_i    (lenc[2]),
    .f2a_req_i     (f2a_req),
    .a2s0_ack_o    (ack[0]),
    .a2s1_ack_o    (ack[1]),
    .a2s2_ack_o    (ack[2]),
    .a2f_val_o     (a2f_val),
    .a2f_data_o    (a2f_data),
    .a2f_id_o      (a2f_id),
    .a2f_sop_o     (a2f_sop),
    .a2f_eop_o     (a2f_eop),
    .a2f_busy_o    (a2f_busy)
  );

  logic [DW-1:0] fq [3][$];
  logic [DW-1:0] wq [3][$];

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < 3; c++) begin
        fq[c].delete();
        wq[c].delete();
        val[c]    <= 1'b0;
        data[c]   <= '0;
        req[c]    <= 1'b0;
        margin[c] <= 6'd32;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (ack[c] && fq[c].size() > 0) begin
          data[c] <= fq[c].pop_front();
          val[c]  <= 1'b1;
        end else begin
          val[c]  <= 1'b0;
        end
        while (wq[c].size() > 0)
          fq[c].push_back(wq[c].pop_front());
        req[c]    <= (fq[c].size() > 0);
        margin[c] <= 6'(32 - fq[c].size());
      end
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    id;
    logic          sop;
    logic          eop;
  } word_t;

  int         cyc = 0;
  int         idle_at = 0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  int         last_m = 2;
  int         id_nx = 0;
  int         id_at = 0;
  logic [1:0] exp_id = 2'd0;
  logic [2:0] exp_ack [int];
  word_t      exp_w   [int];

  int obs_ids [$];
  int sop_cyc [$];
  int eop_cyc [$];
  int ack_cnt [3];
  int nwords = 0;

  always @(negedge clk_i) begin
    logic [2:0] ea;
    bit         hw;
    bit         el [3];
    int         best;
    int         w;
    int         len;
    int         k;
    cyc++;
    if (!rstn_i) begin
      exp_ack.delete();
      exp_w.delete();
      idle_at = 0;
      busy_lo = 0;
      busy_hi = 0;
      last_m  = 2;
      id_nx   = 0;
      id_at   = 0;
      exp_id  = 2'd0;
      chk("rst_outs",
          {ack, a2f_val, a2f_sop, a2f_eop,
           a2f_busy, a2f_id, a2f_data},
          41'd0);
    end else begin
      ea = exp_ack.exists(cyc) ? exp_ack[cyc] : 3'b000;
      exp_ack.delete(cyc);
      chk("ack", ack, ea);
      hw = exp_w.exists(cyc);
      chk("val", a2f_val, hw);
      if (hw) begin
        chk("data", a2f_data, exp_w[cyc].d);
        chk("word_id", a2f_id, exp_w[cyc].id);
        chk("sop", a2f_sop, exp_w[cyc].sop);
        chk("eop", a2f_eop, exp_w[cyc].eop);
        exp_w.delete(cyc);
      end
      chk("busy", a2f_busy,
          (cyc >= busy_lo && cyc < busy_hi));
      if (cyc >= id_at) exp_id = 2'(id_nx);
      chk("id", a2f_id, exp_id);

      if (a2f_val) nwords++;
      if (a2f_val && a2f_sop) begin
        obs_ids.push_back(int'(a2f_id));
        sop_cyc.push_back(cyc);
      end
      if (a2f_val && a2f_eop) eop_cyc.push_back(cyc);
      for (int c = 0; c < 3; c++)
        ack_cnt[c] += int'(ack[c]);

      if (cyc >= idle_at && f2a_req) begin
        best = 4;
        w    = -1;
        for (int c = 0; c < 3; c++) begin
          el[c] = req[c] &&
                  (32 - int'(margin[c]) >= (4 << lenc[c]));
          if (el[c] && int'(prio[c]) < best)
            best = int'(prio[c]);
        end
        for (int j = 1; j <= 3; j++) begin
          k = (last_m + j) % 3;
          if (w < 0 && el[k] && int'(prio[k]) == best)
            w = k;
        end
        if (w >= 0) begin
          len = 4 << lenc[w];
          for (int i = 0; i < len; i++) begin
            k = cyc + 1 + i;
            if (!exp_ack.exists(k)) exp_ack[k] = 3'b000;
            exp_ack[k] = exp_ack[k] | (3'b001 << w);
            exp_w[cyc + 3 + i] = '{d: fq[w][i],
                                   id: 2'(w),
                                   sop: (i == 0),
                                   eop: (i == len - 1)};
          end
          busy_lo = cyc + 1;
          busy_hi = cyc + len + 2;
          idle_at = cyc + len + 2;
          last_m  = w;
          id_nx   = w;
          id_at   = cyc + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int c, input int n);
    repeat (n) wq[c].push_back($urandom);
  endtask

  task automatic clr_obs();
    obs_ids.delete();
    sop_cyc.delete();
    eop_cyc.delete();
    for (int c = 0; c < 3; c++) ack_cnt[c] = 0;
    nwords = 0;
  endtask

  initial begin
    int  ch;
    int  n;
    bit  ok;
    f2a_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      prio[c] = 2'd0;
      lenc[c] = 2'd0;
    end

    tick(3);
    chk("rst_ack", ack, 3'b000);
    chk("rst_busy", a2f_busy, 1'b0);
    chk("rst_val", a2f_val, 1'b0);
    chk("rst_id", a2f_id, 2'd0);
    rstn_i = 1'b1;
    tick(2);

    clr_obs();
    push(1, 4);
    f2a_req = 1'b1;
    tick(12);
    chk("s1_npkt", obs_ids.size(), 1);
    if (obs_ids.size() > 0) chk("s1_id", obs_ids[0], 1);
    chk("s1_acks", ack_cnt[1], 4);
    chk("s1_words", nwords, 4);
    chk("s1_idle", a2f_busy, 1'b0);

    clr_obs();
    push(0, 3);
    tick(10);
    chk("s2_noack", ack_cnt[0], 0);
    push(0, 1);
    tick(12);
    chk("s2_acks", ack_cnt[0], 4);
    chk("s2_npkt", obs_ids.size(), 1);

    f2a_req = 1'b0;
    prio[0] = 2'd2;
    prio[1] = 2'd0;
    prio[2] = 2'd1;
    for (int c = 0; c < 3; c++) push(c, 4);
    tick(3);
    clr_obs();
    f2a_req = 1'b1;
    tick(30);
    chk("s3_npkt", obs_ids.size(), 3);
    if (obs_ids.size() == 3) begin
      chk("s3_ord0", obs_ids[0], 1);
      chk("s3_ord1", obs_ids[1], 2);
      chk("s3_ord2", obs_ids[2], 0);
    end

    f2a_req = 1'b0;
    rstn_i  = 1'b0;
    tick(2);
    rstn_i  = 1'b1;
    for (int c = 0; c < 3; c++) prio[c] = 2'd0;
    push(0, 8);
    push(1, 4);
    push(2, 4);
    tick(3);
    clr_obs();
    f2a_req = 1'b1;
    tick(40);
    chk("s4_npkt", obs_ids.size(), 4);
    if (obs_ids.size() == 4 && eop_cyc.size() >= 3) begin
      chk("s4_ord0", obs_ids[0], 0);
      chk("s4_ord1", obs_ids[1], 1);
      chk("s4_ord2", obs_ids[2], 2);
      chk("s4_ord3", obs_ids[3], 0);
      for (int i = 0; i < 3; i++)
        chk("s4_gap", sop_cyc[i + 1] - eop_cyc[i], 3);
    end

    f2a_req = 1'b0;
    lenc[2] = 2'd3;
    push(2, 32);
    tick(3);
    chk("s5_full", margin[2], 6'd0);
    clr_obs();
    f2a_req = 1'b1;
    tick(45);
    chk("s5_acks", ack_cnt[2], 32);
    chk("s5_words", nwords, 32);
    chk("s5_margin", margin[2], 6'd32);
    lenc[2] = 2'd0;

    clr_obs();
    push(1, 4);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick(1);
      if (ack[1]) ok = 1'b1;
    end
    chk("s6_wait_ack", ok, 1'b1);
    tick(1);
    chk("s6_ack2", ack[1], 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    chk("s6_async",
        {ack, a2f_val, a2f_sop, a2f_eop,
         a2f_busy, a2f_id, a2f_data},
        41'd0);
    tick(2);
    rstn_i = 1'b1;
    tick(1);
    clr_obs();
    push(0, 4);
    push(2, 4);
    tick(20);
    chk("s6_npkt", obs_ids.size(), 2);
    if (obs_ids.size() > 0) chk("s6_first", obs_ids[0], 0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < 3; c++) begin
          prio[c] = 2'($urandom_range(0, 3));
          lenc[c] = ($urandom_range(0, 9) == 0) ?
                    2'd3 : 2'($urandom_range(0, 2));
        end
      end
      ch = $urandom_range(0, 2);
      n  = $urandom_range(0, 3);
      if (fq[ch].size() + wq[ch].size() + n <= 32)
        push(ch, n);
      f2a_req = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    f2a_req = 1'b0;
    tick(50);
    chk("rand_drained", a2f_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
